// File: rtl/maze_walker_if.sv
// maze_walker_if: signal bundle between the video pipeline and the maze walker controller.
// The pipeline side is master; the controller side is slave.
interface maze_walker_if #(
    parameter int COORD_W = 10
);
    logic               params_valid;
    logic [COORD_W-1:0] start_x;
    logic [COORD_W-1:0] start_y;
    logic               frame_start;
    logic               hold;
    logic               sense_valid;
    logic               wall_front;
    logic               wall_left;
    logic               wall_right;
    logic               sense_req;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic [3:0]         heading;
    logic [9:0]         move_cnt;
    logic               done;
    logic               stuck;

    modport master (
        output params_valid, start_x, start_y, frame_start, hold,
        output sense_valid, wall_front, wall_left, wall_right,
        input  sense_req, pos_x, pos_y, heading, move_cnt, done, stuck
    );

    modport slave (
        input  params_valid, start_x, start_y, frame_start, hold,
        input  sense_valid, wall_front, wall_left, wall_right,
        output sense_req, pos_x, pos_y, heading, move_cnt, done, stuck
    );
endinterface

// File: rtl/maze_walker_ctrl.sv
// maze_walker_ctrl: per-frame left-hand wall-following sequencer for the maze agent.
// One accepted decision per frame; flags exit reached (done) or failure (stuck).
module maze_walker_ctrl #(
    parameter int COORD_W     = 10,
    parameter int STEP        = 8,
    parameter int X_MAX       = 701,
    parameter int Y_MAX       = 287,
    parameter int EDGE_MARGIN = 8,
    parameter int MAX_MOVES   = 1023,
    parameter int STUCK_TURNS = 2
) (
    input logic          clk,
    input logic          reset,
    maze_walker_if.slave bus
);
    localparam int CW1  = COORD_W + 1;
    localparam int NM_W = $clog2(STUCK_TURNS + 1);
    localparam logic [CW1-1:0]     STEP_W    = CW1'(STEP);
    localparam logic [CW1-1:0]     X_MAX_W   = CW1'(X_MAX);
    localparam logic [CW1-1:0]     Y_MAX_W   = CW1'(Y_MAX);
    localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] X_MAX_C   = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_MAX_C   = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] LO_EDGE   = COORD_W'(EDGE_MARGIN);
    localparam logic [COORD_W-1:0] X_HI_EDGE = COORD_W'(X_MAX - EDGE_MARGIN);
    localparam logic [COORD_W-1:0] Y_HI_EDGE = COORD_W'(Y_MAX - EDGE_MARGIN);
    localparam logic [9:0]         MC_MAX    = 10'(MAX_MOVES);
    localparam logic [NM_W-1:0]    NM_LIM    = NM_W'(STUCK_TURNS);

    typedef enum logic [2:0] {IDLE, LOAD, SENSE, DECIDE, DONE, STUCK} state_t;

    state_t             state, state_nxt;
    logic [COORD_W-1:0] x_q, y_q, x_nxt, y_nxt, x_mv, y_mv;
    logic [CW1-1:0]     x_add, y_add;
    logic [3:0]         hd_q, hd_nxt, hd_mv;
    logic [9:0]         mc_q, mc_nxt, mc_mv;
    logic [NM_W-1:0]    nm_q, nm_nxt, nm_mv;
    logic [2:0]         walls_q, walls_nxt;
    logic               req_q, done_q, done_nxt, stuck_q, stuck_nxt;
    logic               step, x_sat, y_sat, at_exit, give_up;

    // walls_q is {left, front, right}; heading bits are {down, left, up, right}
    always_comb begin
        step    = ~&walls_q;
        hd_mv   = !walls_q[2] ? {hd_q[2:0], hd_q[3]} :
                  !walls_q[1] ? hd_q :
                  !walls_q[0] ? {hd_q[0], hd_q[3:1]} : {hd_q[1:0], hd_q[3:2]};
        x_add   = {1'b0, x_q} + STEP_W;
        y_add   = {1'b0, y_q} + STEP_W;
        x_sat   = step && ((hd_mv[0] && x_add > X_MAX_W) || (hd_mv[2] && {1'b0, x_q} < STEP_W));
        y_sat   = step && ((hd_mv[3] && y_add > Y_MAX_W) || (hd_mv[1] && {1'b0, y_q} < STEP_W));
        x_mv    = !step    ? x_q :
                  hd_mv[0] ? (x_sat ? X_MAX_C : x_add[COORD_W-1:0]) :
                  hd_mv[2] ? (x_sat ? '0 : x_q - STEP_C) : x_q;
        y_mv    = !step    ? y_q :
                  hd_mv[3] ? (y_sat ? Y_MAX_C : y_add[COORD_W-1:0]) :
                  hd_mv[1] ? (y_sat ? '0 : y_q - STEP_C) : y_q;
        mc_mv   = (step && mc_q != 10'h3ff) ? mc_q + 10'd1 : mc_q;
        nm_mv   = step ? '0 : nm_q + NM_W'(1);
        at_exit = x_sat || y_sat || (mc_mv != '0 && (x_mv <= LO_EDGE || x_mv >= X_HI_EDGE ||
                                                     y_mv <= LO_EDGE || y_mv >= Y_HI_EDGE));
        give_up = nm_mv == NM_LIM || mc_mv == MC_MAX;
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x_q;
        y_nxt     = y_q;
        hd_nxt    = hd_q;
        mc_nxt    = mc_q;
        nm_nxt    = nm_q;
        walls_nxt = walls_q;
        done_nxt  = done_q;
        stuck_nxt = stuck_q;
        if (state != IDLE && !bus.params_valid) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = bus.params_valid ? LOAD : IDLE;
                LOAD: begin
                    x_nxt     = bus.start_x;
                    y_nxt     = bus.start_y;
                    hd_nxt    = 4'b1000;
                    mc_nxt    = '0;
                    nm_nxt    = '0;
                    done_nxt  = 1'b0;
                    stuck_nxt = 1'b0;
                    state_nxt = SENSE;
                end
                // a frame_start coinciding with sense_valid is not consumed here
                SENSE: if (bus.sense_valid) begin
                    walls_nxt = {bus.wall_left, bus.wall_front, bus.wall_right};
                    state_nxt = DECIDE;
                end
                DECIDE: if (bus.frame_start && !bus.hold) begin
                    x_nxt     = x_mv;
                    y_nxt     = y_mv;
                    hd_nxt    = hd_mv;
                    mc_nxt    = mc_mv;
                    nm_nxt    = nm_mv;
                    done_nxt  = at_exit;
                    stuck_nxt = !at_exit && give_up;
                    state_nxt = at_exit ? DONE : give_up ? STUCK : SENSE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            hd_q    <= 4'b1000;
            mc_q    <= '0;
            nm_q    <= '0;
            walls_q <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            hd_q    <= hd_nxt;
            mc_q    <= mc_nxt;
            nm_q    <= nm_nxt;
            walls_q <= walls_nxt;
            req_q   <= state_nxt == SENSE;
            done_q  <= done_nxt;
            stuck_q <= stuck_nxt;
        end
    end

    assign bus.sense_req = req_q;
    assign bus.pos_x     = x_q;
    assign bus.pos_y     = y_q;
    assign bus.heading   = hd_q;
    assign bus.move_cnt  = mc_q;
    assign bus.done      = done_q;
    assign bus.stuck     = stuck_q;
endmodule

// File: tb/tb_maze_walker_ctrl.sv
// tb_maze_walker_ctrl: vector table, hand sequences and a randomized run, all scored
// against a direction-index model of the left-hand walker.
module tb_maze_walker_ctrl;
    localparam int XM = 701, YM = 287, ST = 8, EM = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    maze_walker_if #(.COORD_W(10)) bus ();
    maze_walker_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        bit       pv, fs, hd, sv;
        bit [2:0] w;
        int       sx, sy, ex, ey, eh, emc;
        bit       er, ed, es;
    } vec_t;
    vec_t tbl[$];

    // model mode: 0 idle, 1 load, 2 sense, 3 decide, 4 done, 5 stuck
    // model dir: 0 down, 1 right, 2 up, 3 left (left turn = +1)
    int       m_mode, m_x, m_y, m_dir, m_mc, m_nm;
    bit [2:0] m_w;
    bit       m_req, m_done, m_stuck;
    int       dx[4] = '{0, ST, 0, -ST};
    int       dy[4] = '{ST, 0, -ST, 0};
    int       oh[4] = '{8, 1, 2, 4};

    function automatic vec_t v(input bit pv, fs, hd, sv, input bit [2:0] w, input int sx, sy,
                               input int ex, ey, eh, emc, input bit er, ed, es);
        vec_t r;
        r.pv = pv; r.fs = fs; r.hd = hd; r.sv = sv; r.w = w; r.sx = sx; r.sy = sy;
        r.ex = ex; r.ey = ey; r.eh = eh; r.emc = emc; r.er = er; r.ed = ed; r.es = es;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int ex, ey, eh, emc, input bit er, ed, es);
        check({tag, " pos_x"}, int'(bus.pos_x), ex);
        check({tag, " pos_y"}, int'(bus.pos_y), ey);
        check({tag, " heading"}, int'(bus.heading), eh);
        check({tag, " move_cnt"}, int'(bus.move_cnt), emc);
        check({tag, " sense_req"}, int'(bus.sense_req), int'(er));
        check({tag, " done"}, int'(bus.done), int'(ed));
        check({tag, " stuck"}, int'(bus.stuck), int'(es));
    endtask

    task automatic model_reset();
        m_mode = 0; m_x = 0; m_y = 0; m_dir = 0; m_mc = 0; m_nm = 0;
        m_w = 3'b000; m_req = 0; m_done = 0; m_stuck = 0;
    endtask

    task automatic model_step(input bit pv, fs, hd, sv, input bit [2:0] w, input int sx, sy);
        int nd, nx, ny;
        bit mv, sat, fin;
        if (m_mode != 0 && !pv) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = pv ? 1 : 0;
        end else if (m_mode == 1) begin
            m_x = sx; m_y = sy; m_dir = 0; m_mc = 0; m_nm = 0; m_done = 0; m_stuck = 0; m_mode = 2;
        end else if (m_mode == 2) begin
            if (sv) begin
                m_w = w;
                m_mode = 3;
            end
        end else if (m_mode == 3 && fs && !hd) begin
            // try left, then front, then right, else turn around in place
            nd = !m_w[2] ? (m_dir + 1) % 4 : !m_w[1] ? m_dir : !m_w[0] ? (m_dir + 3) % 4 : (m_dir + 2) % 4;
            mv = m_w != 3'b111;
            nx = m_x + (mv ? dx[nd] : 0);
            ny = m_y + (mv ? dy[nd] : 0);
            sat = nx < 0 || nx > XM || ny < 0 || ny > YM;
            m_x = nx < 0 ? 0 : (nx > XM ? XM : nx);
            m_y = ny < 0 ? 0 : (ny > YM ? YM : ny);
            m_dir = nd;
            if (mv) begin
                m_mc = m_mc < 1023 ? m_mc + 1 : 1023;
                m_nm = 0;
            end else begin
                m_nm++;
            end
            fin = sat || (m_mc > 0 && (m_x <= EM || m_x >= XM - EM || m_y <= EM || m_y >= YM - EM));
            if (fin) begin
                m_done = 1;
                m_mode = 4;
            end else if (m_nm == 2 || m_mc == 1023) begin
                m_stuck = 1;
                m_mode = 5;
            end else begin
                m_mode = 2;
            end
        end
        m_req = m_mode == 2;
    endtask

    task automatic cyc(input bit pv, fs, hd, sv, input bit [2:0] w, input int sx, sy);
        bus.params_valid = pv;
        bus.frame_start  = fs;
        bus.hold         = hd;
        bus.sense_valid  = sv;
        {bus.wall_left, bus.wall_front, bus.wall_right} = w;
        bus.start_x = 10'(sx);
        bus.start_y = 10'(sy);
        @(posedge clk);
        model_step(pv, fs, hd, sv, w, sx, sy);
        #1;
        check_outputs("model", m_x, m_y, oh[m_dir], m_mc, m_req, m_done, m_stuck);
        @(negedge clk);
    endtask

    initial begin
        bit       pv;
        bit [2:0] w;
        int       sx, sy;
        model_reset();
        bus.params_valid = 0; bus.frame_start = 0; bus.hold = 0; bus.sense_valid = 0;
        bus.wall_left = 0; bus.wall_front = 0; bus.wall_right = 0; bus.start_x = '0; bus.start_y = '0;
        repeat (2) @(negedge clk);
        check_outputs("reset", 0, 0, 8, 0, 0, 0, 0);
        reset = 1'b1;

        // pv fs hd sv walls{L,F,R} sx sy | pos_x pos_y heading move_cnt req done stuck
        tbl.push_back(v(1,0,0,0,3'b000,351,20,   0,  0,8,0,0,0,0));
        tbl.push_back(v(1,0,0,0,3'b000,351,20, 351, 20,8,0,1,0,0));
        tbl.push_back(v(1,0,0,1,3'b101,351,20, 351, 20,8,0,0,0,0));
        tbl.push_back(v(1,1,0,0,3'b000,351,20, 351, 28,8,1,1,0,0));
        tbl.push_back(v(1,0,0,1,3'b110,351,20, 351, 28,8,1,0,0,0));
        tbl.push_back(v(1,1,1,0,3'b000,351,20, 351, 28,8,1,0,0,0));
        tbl.push_back(v(1,1,0,0,3'b000,351,20, 343, 28,4,2,1,0,0));
        tbl.push_back(v(1,0,0,1,3'b011,351,20, 343, 28,4,2,0,0,0));
        tbl.push_back(v(1,1,0,0,3'b000,351,20, 343, 36,8,3,1,0,0));
        tbl.push_back(v(1,1,0,1,3'b011,351,20, 343, 36,8,3,0,0,0));
        tbl.push_back(v(1,1,0,0,3'b000,351,20, 351, 36,1,4,1,0,0));
        tbl.push_back(v(1,0,0,1,3'b111,351,20, 351, 36,1,4,0,0,0));
        tbl.push_back(v(1,1,0,0,3'b000,351,20, 351, 36,4,4,1,0,0));
        tbl.push_back(v(1,0,0,1,3'b111,351,20, 351, 36,4,4,0,0,0));
        tbl.push_back(v(1,1,0,0,3'b000,351,20, 351, 36,1,4,0,0,1));
        tbl.push_back(v(0,0,0,0,3'b000,351,20, 351, 36,1,4,0,0,1));
        tbl.push_back(v(1,0,0,0,3'b000,351,270,351, 36,1,4,0,0,1));
        tbl.push_back(v(1,0,0,0,3'b000,351,270,351,270,8,0,1,0,0));
        tbl.push_back(v(1,0,0,1,3'b101,351,270,351,270,8,0,0,0,0));
        tbl.push_back(v(1,1,0,0,3'b000,351,270,351,278,8,1,1,0,0));
        tbl.push_back(v(1,0,0,1,3'b101,351,270,351,278,8,1,0,0,0));
        tbl.push_back(v(1,1,0,0,3'b000,351,270,351,286,8,2,0,1,0));
        tbl.push_back(v(1,1,0,1,3'b000,351,270,351,286,8,2,0,1,0));
        tbl.push_back(v(0,0,0,0,3'b000,351,270,351,286,8,2,0,1,0));
        tbl.push_back(v(1,0,0,0,3'b000,4,100,  351,286,8,2,0,1,0));
        tbl.push_back(v(1,0,0,0,3'b000,4,100,    4,100,8,0,1,0,0));
        tbl.push_back(v(1,0,0,1,3'b110,4,100,    4,100,8,0,0,0,0));
        tbl.push_back(v(1,1,0,0,3'b000,4,100,    0,100,4,1,0,1,0));
        tbl.push_back(v(0,0,0,0,3'b000,4,100,    0,100,4,1,0,1,0));
        tbl.push_back(v(1,0,0,0,3'b000,100,100,  0,100,4,1,0,1,0));
        tbl.push_back(v(1,0,0,0,3'b000,100,100,100,100,8,0,1,0,0));
        tbl.push_back(v(1,0,0,1,3'b101,100,100,100,100,8,0,0,0,0));
        tbl.push_back(v(1,1,0,0,3'b000,100,100,100,108,8,1,1,0,0));
        tbl.push_back(v(0,0,0,0,3'b000,100,100,100,108,8,1,0,0,0));

        foreach (tbl[i]) begin
            cyc(tbl[i].pv, tbl[i].fs, tbl[i].hd, tbl[i].sv, tbl[i].w, tbl[i].sx, tbl[i].sy);
            check_outputs($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].eh, tbl[i].emc,
                          tbl[i].er, tbl[i].ed, tbl[i].es);
        end

        // asynchronous reset in the middle of a walk, away from any clock edge
        cyc(1, 0, 0, 0, 3'b000, 200, 150);
        cyc(1, 0, 0, 0, 3'b000, 200, 150);
        cyc(1, 0, 0, 1, 3'b101, 200, 150);
        cyc(1, 1, 0, 0, 3'b000, 200, 150);
        #2 reset = 1'b0;
        model_reset();
        #1 check_outputs("async_reset", 0, 0, 8, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // circling left turns never reach an edge, so the move limit ends the walk
        cyc(1, 0, 0, 0, 3'b000, 300, 150);
        cyc(1, 0, 0, 0, 3'b000, 300, 150);
        for (int i = 0; i < 1023; i++) begin
            cyc(1, 0, 0, 1, 3'b011, 300, 150);
            cyc(1, 1, 0, 0, 3'b000, 300, 150);
        end
        check_outputs("max_moves", 300, 142, 4, 1023, 0, 0, 1);
        cyc(0, 0, 0, 0, 3'b000, 300, 150);

        pv = 1;
        sx = 351;
        sy = 143;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(63, 0) == 0) pv = !pv;
            if (!pv && $urandom_range(3, 0) == 0) pv = 1;
            if (!pv) begin
                sx = $urandom_range(XM, 0);
                sy = $urandom_range(YM, 0);
            end
            w = 3'($urandom_range(7, 0));
            if (w == 3'b111 && $urandom_range(1, 0) == 1) w = 3'($urandom_range(6, 0));
            cyc(pv, $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0, $urandom_range(2, 0) == 0,
                w, sx, sy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/maze_walker_ctrl.md
Name: maze_walker_ctrl

Overview:
- Per-frame sequencer that moves the maze agent one step per video frame using the left-hand wall-following rule.
- Sits beside the video pixel pipeline and takes three inputs from it:
  - maze start parameters once the first-frame analysis completes;
  - a wall-sense result sampled from the scan window at the current agent position;
  - a frame boundary pulse.
- Drives the agent position/heading back to the pipeline for window sampling and agent drawing, and flags completion (exit reached) or failure (stuck).

Parameters:
COORD_W, 10, width of position coordinates
STEP, 8, pixels moved per accepted move
X_MAX, 701, largest valid horizontal coordinate
Y_MAX, 287, largest valid vertical coordinate
EDGE_MARGIN, 8, distance from any image edge that counts as exit
MAX_MOVES, 1023, move count at which walker declares stuck
STUCK_TURNS, 2, consecutive no-move decisions that declare stuck

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
params_valid  in  1  level; maze start parameters valid
start_x  in  COORD_W  start horizontal coordinate, sampled in LOAD
start_y  in  COORD_W  start vertical coordinate, sampled in LOAD
frame_start  in  1  one-cycle pulse at frame boundary
hold  in  1  level; 1 suppresses frame-driven moves
sense_valid  in  1  one-cycle pulse; wall flags valid this cycle
wall_front  in  1  1 = wall one STEP ahead along heading
wall_left  in  1  1 = wall on left of heading
wall_right  in  1  1 = wall on right of heading
sense_req  out  1  level; controller awaits sense result
pos_x  out  COORD_W  agent horizontal coordinate
pos_y  out  COORD_W  agent vertical coordinate
heading  out  4  one-hot direction: 1000 down(+y), 0100 left(-x), 0010 up(-y), 0001 right(+x)
move_cnt  out  10  accepted moves since LOAD, saturating
done  out  1  sticky; exit reached
stuck  out  1  sticky; walker failed

Behaviour:
- Reset values:
  - state IDLE;
  - pos_x = 0, pos_y = 0, heading = 1000;
  - move_cnt = 0, sense_req = 0, done = 0, stuck = 0;
  - internal no-move counter = 0, latched walls = 0.
- All outputs are registered.
- States are IDLE, LOAD, SENSE, DECIDE, DONE, STUCK.
- IDLE:
  - exit to LOAD when params_valid = 1.
- LOAD (1 cycle):
  - pos_x <= start_x, pos_y <= start_y, heading <= 1000;
  - clear move_cnt, no-move counter, done and stuck;
  - go to SENSE.
- SENSE:
  - sense_req = 1 in every cycle spent in SENSE; it rises the cycle after entry.
  - On sense_valid: latch the three wall flags, go to DECIDE, and drop sense_req the next cycle.
  - frame_start without sense_valid: stay in SENSE; no move, no count.
  - sense_valid and frame_start in the same cycle: latch walls and go to DECIDE. That frame_start is NOT consumed; the move waits for the next frame_start.
- DECIDE: on frame_start with hold = 0, apply the first matching rule:
  - left open: heading rotates left (down→right, right→up, up→left, left→down), then step;
  - else front open: step along current heading;
  - else right open: heading rotates right, then step;
  - else: heading reverses, no step, no-move counter +1.
- A step adds or subtracts STEP on the axis of the new heading, increments move_cnt and clears the no-move counter.
- The new pos/heading are visible the cycle after frame_start. Next state is SENSE unless a terminal condition holds.
- hold = 1: frame_start is ignored in DECIDE; the state is kept.
- Arithmetic and saturation:
  - subtraction that would go below 0 saturates at 0;
  - addition that would exceed X_MAX / Y_MAX saturates at the max.
- Terminal checks are evaluated on the updated values, with priority DONE over STUCK:
  - DONE: pos_x ≤ EDGE_MARGIN, pos_x ≥ X_MAX−EDGE_MARGIN, pos_y ≥ Y_MAX−EDGE_MARGIN, or pos_y ≤ EDGE_MARGIN, with move_cnt > 0. Also reached when any saturation occurred.
  - STUCK: no-move counter = STUCK_TURNS, or move_cnt = MAX_MOVES.
- DONE and STUCK:
  - sticky; position frozen; sense_req = 0;
  - left only via params_valid falling or reset.
- params_valid = 0 in any non-IDLE state: go to IDLE next cycle.
  - pos/heading/move_cnt are retained; done and stuck are retained until the next LOAD.
  - params_valid rising again re-enters LOAD.
- Reset mid-operation: all registers take their reset values asynchronously. Operation resumes from IDLE after reset rises.

Test Plan:
- Reset, params_valid = 1, start (351,20) → LOAD then SENSE; sense_req = 1 from the 3rd cycle; pos = (351,20), heading = 1000.
- sense_valid with L=1,F=0,R=1, then frame_start → pos = (351,28), heading = 1000, move_cnt = 1; sense_req re-asserts.
- Walls L=1,F=1,R=0 at heading 1000 → heading 0100, pos_x −8. Walls L=0 at heading 1000 → heading 0001, pos_x +8.
- Two consecutive sense results L=F=R=1 → heading flips twice with no step; stuck = 1 after the second frame_start; sense_req = 0.
- sense_valid coincident with frame_start → no move that frame; move on the following frame_start. hold = 1 across frame_start → no change.
- Start (351,270), heading down, front open → pos_y = 278 ≥ 279? no; next step pos_y = 286 → done = 1.
- Start pos_x = 4, heading left → saturates at 0 and done = 1.
- params_valid dropped mid-walk → IDLE next cycle with pos retained.
- Async reset pulse → all outputs at reset values.
